// File: rtl/countdown_timer.sv
// Loadable hh:mm:ss countdown timer with a 1 s prescaler, pause/resume and a done pulse.
// Time is kept in the same binary h/m/s encoding as the wall clock; every output is registered.
module countdown_timer #(
    parameter int TICK_DIV   = 100000000,
    parameter int TICK_WIDTH = 27
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [4:0] hours_i,
    input  logic [5:0] minutes_i,
    input  logic [5:0] seconds_i,
    input  logic       start_i,
    input  logic       pause_i,
    output logic [4:0] hours_o,
    output logic [5:0] minutes_o,
    output logic [5:0] seconds_o,
    output logic       running_o,
    output logic       done_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [TICK_WIDTH-1:0] TICK_MAX = TICK_WIDTH'(TICK_DIV - 1);

    state_t                state;
    logic [TICK_WIDTH-1:0] presc;

    logic [4:0] load_h;
    logic [5:0] load_m;
    logic [5:0] load_s;
    logic [4:0] dec_h;
    logic [5:0] dec_m;
    logic [5:0] dec_s;
    logic       time_zero;
    logic       dec_zero;

    always_comb begin
        load_h = (hours_i   > 5'd23) ? 5'd23 : hours_i;
        load_m = (minutes_i > 6'd59) ? 6'd59 : minutes_i;
        load_s = (seconds_i > 6'd59) ? 6'd59 : seconds_i;
    end

    // One-second step with borrow; at 00:00:00 it holds, so it can never underflow.
    always_comb begin
        dec_h = hours_o;
        dec_m = minutes_o;
        dec_s = seconds_o;
        if (seconds_o != 6'd0) begin
            dec_s = seconds_o - 6'd1;
        end else if (minutes_o != 6'd0) begin
            dec_m = minutes_o - 6'd1;
            dec_s = 6'd59;
        end else if (hours_o != 5'd0) begin
            dec_h = hours_o - 5'd1;
            dec_m = 6'd59;
            dec_s = 6'd59;
        end
    end

    assign time_zero = (hours_o == 5'd0) && (minutes_o == 6'd0) && (seconds_o == 6'd0);
    assign dec_zero  = (dec_h == 5'd0) && (dec_m == 6'd0) && (dec_s == 6'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            presc     <= '0;
            hours_o   <= 5'd0;
            minutes_o <= 6'd0;
            seconds_o <= 6'd0;
            running_o <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (load_i) begin
                state     <= IDLE;
                presc     <= '0;
                hours_o   <= load_h;
                minutes_o <= load_m;
                seconds_o <= load_s;
                running_o <= 1'b0;
            end else begin
                case (state)
                    IDLE, PAUSED: begin
                        if (start_i && !time_zero) begin
                            state     <= RUN;
                            running_o <= 1'b1;
                        end
                    end
                    RUN: begin
                        // Pausing keeps the prescaler so a resume finishes the partial second.
                        if (pause_i) begin
                            state     <= PAUSED;
                            running_o <= 1'b0;
                        end else if (presc == TICK_MAX) begin
                            presc     <= '0;
                            hours_o   <= dec_h;
                            minutes_o <= dec_m;
                            seconds_o <= dec_s;
                            if (dec_zero) begin
                                state     <= DONE;
                                running_o <= 1'b0;
                                done_o    <= 1'b1;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state     <= IDLE;
                        running_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
